// File: rtl/iq_issue.sv
// Issue-side instruction queue between ID and REG: circular buffer taking up to two
// decoded instructions per cycle and presenting up to two for issue after a RAW/single check.
module iq_issue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAYLOAD_W = 128
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   flush,

    input  logic                   id_readygo,
    output logic                   id_allowin,
    input  logic                   id_valid1,
    input  logic [PAYLOAD_W-1:0]   id_payload0,
    input  logic [PAYLOAD_W-1:0]   id_payload1,
    input  logic [4:0]             id_rd0,
    input  logic [4:0]             id_rd1,
    input  logic [4:0]             id_rj0,
    input  logic [4:0]             id_rj1,
    input  logic [4:0]             id_rk0,
    input  logic [4:0]             id_rk1,
    input  logic                   id_is_ALU_0,
    input  logic                   id_is_ALU_1,
    input  logic                   id_single0,
    input  logic                   id_single1,

    input  logic                   reg_allowin,
    output logic                   reg_readygo,
    output logic                   iq_valid1,
    output logic [PAYLOAD_W-1:0]   iq_payload0,
    output logic [PAYLOAD_W-1:0]   iq_payload1,
    output logic [4:0]             iq_rd0,
    output logic [4:0]             iq_rd1,
    output logic [4:0]             iq_rj0,
    output logic [4:0]             iq_rj1,
    output logic [4:0]             iq_rk0,
    output logic [4:0]             iq_rk1,
    output logic                   iq_is_ALU_0,
    output logic                   iq_is_ALU_1,
    output logic [$clog2(DEPTH):0] iq_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [4:0]           rd;
        logic [4:0]           rj;
        logic [4:0]           rk;
        logic                 is_alu;
        logic                 single;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    entry_t           wr0;
    entry_t           wr1;
    entry_t           slot0;
    entry_t           slot1;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic             push;
    logic             pop;
    logic             ready;
    logic             dual;
    logic             raw;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);
    assign slot0   = mem[head];
    assign slot1   = mem[head_p1];

    assign wr0 = '{payload: id_payload0, rd: id_rd0, rj: id_rj0, rk: id_rk0,
                   is_alu: id_is_ALU_0, single: id_single0};
    assign wr1 = '{payload: id_payload1, rd: id_rd1, rj: id_rj1, rk: id_rk1,
                   is_alu: id_is_ALU_1, single: id_single1};

    // Handshakes depend only on registered occupancy, never on this cycle's pop.
    assign id_allowin  = (count <= CNT_W'(DEPTH - 2));
    assign ready       = (count != '0);
    assign reg_readygo = ready;

    // Slot1 may only pair with slot0 if it does not read slot0's destination.
    assign raw  = (slot0.rd != 5'd0) && ((slot0.rd == slot1.rj) || (slot0.rd == slot1.rk));
    assign dual = (count >= CNT_W'(2)) && !slot0.single && !slot1.single
                  && slot0.is_alu && slot1.is_alu && !raw;
    assign iq_valid1 = dual;

    assign push   = id_readygo & id_allowin;
    assign pop    = ready & reg_allowin;
    assign push_n = push ? (2'd1 + {1'b0, id_valid1}) : 2'd0;
    assign pop_n  = pop  ? (2'd1 + {1'b0, dual})      : 2'd0;

    assign iq_payload0 = ready ? slot0.payload : '0;
    assign iq_rd0      = ready ? slot0.rd      : 5'd0;
    assign iq_rj0      = ready ? slot0.rj      : 5'd0;
    assign iq_rk0      = ready ? slot0.rk      : 5'd0;
    assign iq_is_ALU_0 = ready ? slot0.is_alu  : 1'b0;

    assign iq_payload1 = dual ? slot1.payload : '0;
    assign iq_rd1      = dual ? slot1.rd      : 5'd0;
    assign iq_rj1      = dual ? slot1.rj      : 5'd0;
    assign iq_rk1      = dual ? slot1.rk      : 5'd0;
    assign iq_is_ALU_1 = dual ? slot1.is_alu  : 1'b0;

    assign iq_count = count;

    // Pointer and occupancy state; flush wins over any transfer in the same cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    // Entry storage is left unreset; unoccupied entries are masked at the outputs.
    always_ff @(posedge aclk) begin
        if (push && !flush) begin
            mem[tail] <= wr0;
            if (id_valid1) begin
                mem[tail_p1] <= wr1;
            end
        end
    end

    always @(posedge aclk) begin
        if (!areset) begin
            assert (count <= CNT_W'(DEPTH))
                else $error("iq_issue: occupancy %0d exceeds depth", count);
            assert (!push || (count <= CNT_W'(DEPTH - 2)))
                else $error("iq_issue: push accepted without room for a pair");
            assert (!pop || (count != '0))
                else $error("iq_issue: pop from empty queue");
        end
    end

endmodule

// File: tb/tb_iq_issue.sv
// Directed + randomised bench for iq_issue: a bench-side queue of pushed entries is
// popped as the DUT issues, and every presented field is compared against it.
module tb_iq_issue;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned PAYLOAD_W = 128;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [4:0]           rd;
        logic [4:0]           rj;
        logic [4:0]           rk;
        logic                 alu;
        logic                 single;
    } ent_t;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic                 flush;
    logic                 id_readygo;
    logic                 id_allowin;
    logic                 id_valid1;
    logic [PAYLOAD_W-1:0] id_payload0, id_payload1;
    logic [4:0]           id_rd0, id_rd1, id_rj0, id_rj1, id_rk0, id_rk1;
    logic                 id_is_ALU_0, id_is_ALU_1, id_single0, id_single1;
    logic                 reg_allowin;
    logic                 reg_readygo;
    logic                 iq_valid1;
    logic [PAYLOAD_W-1:0] iq_payload0, iq_payload1;
    logic [4:0]           iq_rd0, iq_rd1, iq_rj0, iq_rj1, iq_rk0, iq_rk1;
    logic                 iq_is_ALU_0, iq_is_ALU_1;
    logic [3:0]           iq_count;

    ent_t mq[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 aclk = ~aclk;

    iq_issue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
        .aclk(aclk), .areset(areset), .flush(flush),
        .id_readygo(id_readygo), .id_allowin(id_allowin), .id_valid1(id_valid1),
        .id_payload0(id_payload0), .id_payload1(id_payload1),
        .id_rd0(id_rd0), .id_rd1(id_rd1), .id_rj0(id_rj0), .id_rj1(id_rj1),
        .id_rk0(id_rk0), .id_rk1(id_rk1),
        .id_is_ALU_0(id_is_ALU_0), .id_is_ALU_1(id_is_ALU_1),
        .id_single0(id_single0), .id_single1(id_single1),
        .reg_allowin(reg_allowin), .reg_readygo(reg_readygo), .iq_valid1(iq_valid1),
        .iq_payload0(iq_payload0), .iq_payload1(iq_payload1),
        .iq_rd0(iq_rd0), .iq_rd1(iq_rd1), .iq_rj0(iq_rj0), .iq_rj1(iq_rj1),
        .iq_rk0(iq_rk0), .iq_rk1(iq_rk1),
        .iq_is_ALU_0(iq_is_ALU_0), .iq_is_ALU_1(iq_is_ALU_1), .iq_count(iq_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [4:0] rd, input logic [4:0] rj,
                                input logic [4:0] rk, input logic alu, input logic sg);
        ent_t e;
        e.payload = {$urandom(), $urandom(), $urandom(), $urandom()};
        e.rd = rd; e.rj = rj; e.rk = rk; e.alu = alu; e.single = sg;
        return e;
    endfunction

    // Pairing rule taken from the issue policy: both ALU, neither single, no RAW on rd0.
    function automatic logic exp_dual();
        if (mq.size() < 2) return 1'b0;
        if (mq[0].single || mq[1].single) return 1'b0;
        if (!mq[0].alu || !mq[1].alu) return 1'b0;
        if ((mq[0].rd != 5'd0) && ((mq[0].rd == mq[1].rj) || (mq[0].rd == mq[1].rk)))
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outputs(input string ctx);
        ent_t s0, s1;
        logic dl;
        s0 = '0;
        s1 = '0;
        dl = exp_dual();
        if (mq.size() > 0) s0 = mq[0];
        if (dl) s1 = mq[1];
        chk({ctx, ".readygo"}, reg_readygo, mq.size() > 0);
        chk({ctx, ".valid1"},  iq_valid1, dl);
        chk({ctx, ".count"},   iq_count, mq.size());
        chk({ctx, ".allowin"}, id_allowin, (int'(DEPTH) - mq.size()) >= 2);
        chk({ctx, ".pay0"},    iq_payload0, s0.payload);
        chk({ctx, ".regs0"},   {iq_rd0, iq_rj0, iq_rk0, iq_is_ALU_0}, {s0.rd, s0.rj, s0.rk, s0.alu});
        chk({ctx, ".pay1"},    iq_payload1, s1.payload);
        chk({ctx, ".regs1"},   {iq_rd1, iq_rj1, iq_rk1, iq_is_ALU_1}, {s1.rd, s1.rj, s1.rk, s1.alu});
    endtask

    // Drive one cycle, update the bench queue from pre-edge state, then check after the edge.
    task automatic tick(input string ctx, input logic rg, input logic v1, input ent_t e0,
                        input ent_t e1, input logic ra, input logic fl);
        logic allow, ready, dl;
        id_readygo = rg; id_valid1 = v1; reg_allowin = ra; flush = fl;
        id_payload0 = e0.payload; id_rd0 = e0.rd; id_rj0 = e0.rj; id_rk0 = e0.rk;
        id_is_ALU_0 = e0.alu; id_single0 = e0.single;
        id_payload1 = e1.payload; id_rd1 = e1.rd; id_rj1 = e1.rj; id_rk1 = e1.rk;
        id_is_ALU_1 = e1.alu; id_single1 = e1.single;
        allow = (int'(DEPTH) - mq.size()) >= 2;
        ready = mq.size() > 0;
        dl    = exp_dual();
        if (fl) begin
            mq.delete();
        end else begin
            if (ready && ra) begin
                void'(mq.pop_front());
                if (dl) void'(mq.pop_front());
            end
            if (rg && allow) begin
                mq.push_back(e0);
                if (v1) mq.push_back(e1);
            end
        end
        @(posedge aclk);
        #1;
        check_outputs(ctx);
    endtask

    task automatic idle(input string ctx, input logic ra);
        tick(ctx, 1'b0, 1'b0, '0, '0, ra, 1'b0);
    endtask

    task automatic drain(input string ctx);
        for (int i = 0; i < 20 && mq.size() > 0; i++) idle(ctx, 1'b1);
        chk({ctx, ".empty"}, iq_count, 0);
    endtask

    initial begin
        areset = 1'b1; flush = 1'b0; id_readygo = 1'b0; id_valid1 = 1'b0;
        id_payload0 = '0; id_payload1 = '0; id_rd0 = '0; id_rd1 = '0; id_rj0 = '0;
        id_rj1 = '0; id_rk0 = '0; id_rk1 = '0; id_is_ALU_0 = 1'b0; id_is_ALU_1 = 1'b0;
        id_single0 = 1'b0; id_single1 = 1'b0; reg_allowin = 1'b0;
        #2;
        check_outputs("reset");
        @(negedge aclk);
        areset = 1'b0;

        // Independent pair dual-issues one cycle after push.
        tick("tp1", 1, 1, mk(3, 1, 2, 1, 0), mk(5, 4, 6, 1, 0), 1, 0);
        chk("tp1.dual_const", iq_valid1, 1);
        idle("tp1b", 1);
        chk("tp1.count0", iq_count, 0);

        // RAW on rd0 -> rj1 splits the pair.
        tick("raw", 1, 1, mk(3, 1, 2, 1, 0), mk(5, 3, 6, 1, 0), 1, 0);
        chk("raw.single_const", iq_valid1, 0);
        chk("raw.count2", iq_count, 2);
        idle("raw_b", 1);
        chk("raw.count1", iq_count, 1);
        chk("raw.rd_second", iq_rd0, 5);
        idle("raw_c", 1);

        // r0 destination never creates a hazard.
        tick("r0", 1, 1, mk(0, 1, 2, 1, 0), mk(4, 5, 0, 1, 0), 1, 0);
        chk("r0.dual_const", iq_valid1, 1);
        drain("r0");

        tick("sg0", 1, 1, mk(1, 2, 3, 1, 1), mk(4, 5, 6, 1, 0), 1, 0);
        chk("sg0.single_const", iq_valid1, 0);
        drain("sg0");
        tick("sg1", 1, 1, mk(1, 2, 3, 1, 0), mk(4, 5, 6, 1, 1), 1, 0);
        chk("sg1.single_const", iq_valid1, 0);
        drain("sg1");
        tick("nalu", 1, 1, mk(1, 2, 3, 1, 0), mk(4, 5, 6, 0, 0), 1, 0);
        drain("nalu");

        // Fill to DEPTH while stalled, then stream through pointer wrap.
        for (int i = 0; i < 4; i++)
            tick("fill", 1, 1, mk(5'(i + 1), 0, 0, 1, 0), mk(5'(i + 9), 0, 0, 1, 0), 0, 0);
        chk("full.count", iq_count, 8);
        chk("full.allowin", id_allowin, 0);
        tick("full_stall", 1, 1, mk(7, 0, 0, 1, 0), mk(8, 0, 0, 1, 0), 0, 0);
        for (int i = 0; i < 12; i++)
            tick("wrap", 1, 1, mk(5'(i), 5'(i + 3), 0, 1, 0), mk(5'(i + 1), 0, 5'(i), 1, 0), 1, 0);
        drain("wrap");

        // Occupancy 5, then flush with a group offered.
        tick("f_a", 1, 1, mk(1, 0, 0, 1, 0), mk(2, 0, 0, 1, 0), 0, 0);
        tick("f_b", 1, 1, mk(3, 0, 0, 1, 0), mk(4, 0, 0, 1, 0), 0, 0);
        tick("f_c", 1, 0, mk(5, 0, 0, 1, 0), '0, 0, 0);
        chk("flush.pre_count", iq_count, 5);
        chk("flush.pre_allowin", id_allowin, 1);
        tick("flush", 1, 1, mk(6, 0, 0, 1, 0), mk(7, 0, 0, 1, 0), 1, 1);
        chk("flush.count", iq_count, 0);
        chk("flush.readygo", reg_readygo, 0);
        chk("flush.allowin", id_allowin, 1);

        // Random traffic with a small register space to provoke hazards.
        for (int i = 0; i < 150; i++) begin
            tick("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 7) == 0)),
                 mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 7) == 0)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        // Asynchronous reset mid-stream clears outputs before the next edge.
        tick("ar_a", 1, 1, mk(1, 0, 0, 1, 0), mk(2, 0, 0, 1, 0), 0, 0);
        id_readygo = 1'b0;
        #1;
        areset = 1'b1;
        #1;
        chk("areset.readygo", reg_readygo, 0);
        chk("areset.count", iq_count, 0);
        chk("areset.allowin", id_allowin, 1);
        chk("areset.valid1", iq_valid1, 0);
        chk("areset.pay0", iq_payload0, 0);
        mq.delete();
        @(negedge aclk);
        areset = 1'b0;
        idle("post_reset", 1);
        tick("post_reset_push", 1, 1, mk(9, 1, 1, 1, 0), mk(10, 2, 2, 1, 0), 1, 0);
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
